butterfly_r2_pipe: RTL and testbench

BUTTERFLY_R2_PIPE -- requirements
Module: butterfly_r2_pipe

---
 rtl/fft_pkg.sv | 14 +
 rtl/bfly_addsub_sat.sv | 45 ++++
 rtl/butterfly_r2_pipe.sv | 130 +++++++++++++
 tb/tb_butterfly_r2_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and legal parameter ranges for the radix-2 butterfly datapath.
package fft_pkg;

    typedef enum logic {
        BFLY_PLAIN = 1'b0,
        BFLY_JROT  = 1'b1
    } bfly_mode_e;

    localparam int PIPE_STAGES_MIN = 1;
    localparam int PIPE_STAGES_MAX = 4;
    localparam int DATA_WIDTH_MIN  = 4;
    localparam int DATA_WIDTH_MAX  = 32;

endpackage

// File: rtl/bfly_addsub_sat.sv
// One butterfly component: full-precision add/sub, then either round-half-up
// halving or clamping to the signed output range.
module bfly_addsub_sat #(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    input  logic                         sub_i,
    input  logic                         scale_i,
    output logic signed [DATA_WIDTH-1:0] y_o,
    output logic                         ovf_o
);

    localparam int W = DATA_WIDTH;
    localparam logic signed [W:0] SUM_MAX = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] SUM_MIN = {2'b11, {(W-1){1'b0}}};

    logic signed [W:0] a_x;
    logic signed [W:0] b_x;
    logic signed [W:0] sum;
    logic signed [W:0] half;

    always_comb begin
        a_x  = {a_i[W-1], a_i};
        b_x  = {b_i[W-1], b_i};
        sum  = sub_i ? (a_x - b_x) : (a_x + b_x);
        // (sum+1)>>>1 equals floor(sum/2) plus the dropped LSB.
        half = $signed({sum[W], sum[W:1]}) + $signed({{W{1'b0}}, sum[0]});
        y_o   = '0;
        ovf_o = 1'b0;
        if (scale_i) begin
            // Only max minus min rounds up past the top code; pin it silently.
            y_o = (half > SUM_MAX) ? SUM_MAX[W-1:0] : half[W-1:0];
        end else if (sum > SUM_MAX) begin
            y_o   = SUM_MAX[W-1:0];
            ovf_o = 1'b1;
        end else if (sum < SUM_MIN) begin
            y_o   = SUM_MIN[W-1:0];
            ovf_o = 1'b1;
        end else begin
            y_o = sum[W-1:0];
        end
    end

endmodule

// File: rtl/butterfly_r2_pipe.sv
// Pipelined radix-2 butterfly (plain or j-rotated) with per-sample scaling,
// a global stall enable and a sticky overflow flag.
module butterfly_r2_pipe
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int PIPE_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic                         mode,
    input  logic                         scale,
    input  logic signed [DATA_WIDTH-1:0] real_in0,
    input  logic signed [DATA_WIDTH-1:0] imag_in0,
    input  logic signed [DATA_WIDTH-1:0] real_in1,
    input  logic signed [DATA_WIDTH-1:0] imag_in1,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] real_out0,
    output logic signed [DATA_WIDTH-1:0] imag_out0,
    output logic signed [DATA_WIDTH-1:0] real_out1,
    output logic signed [DATA_WIDTH-1:0] imag_out1,
    output logic                         out_ovf,
    input  logic                         ovf_clr,
    output logic                         ovf_sticky
);

    localparam int W = DATA_WIDTH;
    localparam int P = PIPE_STAGES;

    generate
        if (P < PIPE_STAGES_MIN || P > PIPE_STAGES_MAX) begin : g_bad_stages
            $error("butterfly_r2_pipe: PIPE_STAGES out of range 1..4");
        end
        if (W < DATA_WIDTH_MIN || W > DATA_WIDTH_MAX) begin : g_bad_width
            $error("butterfly_r2_pipe: DATA_WIDTH out of range 4..32");
        end
    endgenerate

    logic signed [W-1:0] op_a [4];
    logic signed [W-1:0] op_b [4];
    logic signed [W-1:0] res  [4];
    logic                sub_sel  [4];
    logic                comp_ovf [4];
    logic                jrot;

    assign jrot = (bfly_mode_e'(mode) == BFLY_JROT);

    // Component order: y0.re, y0.im, y1.re, y1.im.
    always_comb begin
        op_a[0]    = real_in0;
        op_a[1]    = imag_in0;
        op_a[2]    = real_in0;
        op_a[3]    = imag_in0;
        op_b[0]    = jrot ? imag_in1 : real_in1;
        op_b[1]    = jrot ? real_in1 : imag_in1;
        op_b[2]    = jrot ? imag_in1 : real_in1;
        op_b[3]    = jrot ? real_in1 : imag_in1;
        sub_sel[0] = jrot;
        sub_sel[1] = 1'b0;
        sub_sel[2] = ~jrot;
        sub_sel[3] = 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_comp
            bfly_addsub_sat #(
                .DATA_WIDTH(W)
            ) u_comp (
                .a_i    (op_a[gi]),
                .b_i    (op_b[gi]),
                .sub_i  (sub_sel[gi]),
                .scale_i(scale),
                .y_o    (res[gi]),
                .ovf_o  (comp_ovf[gi])
            );
        end
    endgenerate

    logic [4*W-1:0] data_d;
    logic           ovf_d;
    logic [4*W-1:0] data_q [P];
    logic [P-1:0]   valid_q;
    logic [P-1:0]   ovf_q;
    logic           ovf_sticky_q;

    assign data_d = {res[3], res[2], res[1], res[0]};
    assign ovf_d  = in_valid & (comp_ovf[0] | comp_ovf[1] | comp_ovf[2] | comp_ovf[3]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < P; s++) begin
                data_q[s] <= '0;
            end
            valid_q <= '0;
            ovf_q   <= '0;
        end else if (en) begin
            data_q[0]  <= data_d;
            valid_q[0] <= in_valid;
            ovf_q[0]   <= ovf_d;
            for (int s = 1; s < P; s++) begin
                data_q[s]  <= data_q[s-1];
                valid_q[s] <= valid_q[s-1];
                ovf_q[s]   <= ovf_q[s-1];
            end
        end
    end

    // Set has priority over clear so a flagged sample is never missed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_q <= 1'b0;
        end else if (out_valid && out_ovf) begin
            ovf_sticky_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_q <= 1'b0;
        end
    end

    assign out_valid  = valid_q[P-1];
    assign out_ovf    = ovf_q[P-1];
    assign real_out0  = data_q[P-1][0*W +: W];
    assign imag_out0  = data_q[P-1][1*W +: W];
    assign real_out1  = data_q[P-1][2*W +: W];
    assign imag_out1  = data_q[P-1][3*W +: W];
    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Scoreboard bench: three instances (2, 1 and 4 stages) share one stimulus stream.
module tb_butterfly_r2_pipe;

    localparam int NV = 9;

    logic clk = 1'b0;
    logic rst_n, en, in_valid, mode, scale, ovf_clr;
    logic signed [15:0] r0, i0, r1, i1;

    logic               ov [3];
    logic               oovf [3];
    logic               osticky [3];
    logic signed [15:0] or0 [3];
    logic signed [15:0] oi0 [3];
    logic signed [15:0] or1 [3];
    logic signed [15:0] oi1 [3];

    logic vm [NV];
    logic vs [NV];
    int   vr0 [NV], vi0 [NV], vr1 [NV], vi1 [NV];
    int   er0 [NV], ei0 [NV], er1 [NV], ei1 [NV];
    logic eo [NV];

    int q_idx [3][$];
    int q_stamp [3][$];
    int cur_idx;
    int en_cnt;
    int checks;
    int errors;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            butterfly_r2_pipe #(
                .DATA_WIDTH (16),
                .PIPE_STAGES((gi == 0) ? 2 : ((gi == 1) ? 1 : 4))
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (en),
                .in_valid  (in_valid),
                .mode      (mode),
                .scale     (scale),
                .real_in0  (r0),
                .imag_in0  (i0),
                .real_in1  (r1),
                .imag_in1  (i1),
                .out_valid (ov[gi]),
                .real_out0 (or0[gi]),
                .imag_out0 (oi0[gi]),
                .real_out1 (or1[gi]),
                .imag_out1 (oi1[gi]),
                .out_ovf   (oovf[gi]),
                .ovf_clr   (ovf_clr),
                .ovf_sticky(osticky[gi])
            );
        end
    endgenerate

    function automatic int ps_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    task automatic setv(input int k, input logic m, input logic s,
                        input int a0, input int b0, input int a1, input int b1,
                        input int y0r, input int y0i, input int y1r, input int y1i,
                        input logic o);
        vm[k] = m;  vs[k] = s;
        vr0[k] = a0; vi0[k] = b0; vr1[k] = a1; vi1[k] = b1;
        er0[k] = y0r; ei0[k] = y0i; er1[k] = y1r; ei1[k] = y1i;
        eo[k] = o;
    endtask

    task automatic drive(input int k, input logic v);
        @(posedge clk);
        #1;
        en       = 1'b1;
        in_valid = v;
        mode     = vm[k];
        scale    = vs[k];
        r0       = 16'(vr0[k]);
        i0       = 16'(vi0[k]);
        r1       = 16'(vr1[k]);
        i1       = 16'(vi1[k]);
        cur_idx  = k;
    endtask

    task automatic stall(input int n);
        @(posedge clk);
        #1;
        en       = 1'b0;
        in_valid = 1'b1;
        mode     = vm[8];
        scale    = vs[8];
        r0       = 16'(vr0[8]);
        i0       = 16'(vi0[8]);
        r1       = 16'(vr1[8]);
        i1       = 16'(vi1[8]);
        cur_idx  = 8;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic check_idle(input string tag);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ov[d] !== 1'b0 || oovf[d] !== 1'b0 || osticky[d] !== 1'b0 ||
                or0[d] !== 16'sd0 || oi0[d] !== 16'sd0 || or1[d] !== 16'sd0 || oi1[d] !== 16'sd0) begin
                errors++;
                $display("FAIL %s dut%0d: valid=%0b ovf=%0b sticky=%0b data=(%0d,%0d,%0d,%0d) required all 0",
                         tag, d, ov[d], oovf[d], osticky[d], or0[d], oi0[d], or1[d], oi1[d]);
            end
        end
    endtask

    task automatic check_sticky(input string tag, input logic exp);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (osticky[d] !== exp) begin
                errors++;
                $display("FAIL %s dut%0d: ovf_sticky=%0b required %0b", tag, d, osticky[d], exp);
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && en) en_cnt++;
    end

    // Monitor then scoreboard push, both sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (ov[d]) begin
                    if (q_idx[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out dut%0d: out_valid=1 with no sample expected", d);
                    end else begin
                        int k;
                        int lat;
                        k = q_idx[d][0];
                        checks++;
                        if (int'(or0[d]) != er0[k] || int'(oi0[d]) != ei0[k] ||
                            int'(or1[d]) != er1[k] || int'(oi1[d]) != ei1[k] || oovf[d] !== eo[k]) begin
                            errors++;
                            $display("FAIL data dut%0d vec%0d: got (%0d,%0d,%0d,%0d) ovf=%0b required (%0d,%0d,%0d,%0d) ovf=%0b",
                                     d, k, or0[d], oi0[d], or1[d], oi1[d], oovf[d],
                                     er0[k], ei0[k], er1[k], ei1[k], eo[k]);
                        end else begin
                            $display("out dut%0d vec%0d: (%0d,%0d,%0d,%0d) ovf=%0b%s", d, k,
                                     or0[d], oi0[d], or1[d], oi1[d], oovf[d], en ? "" : " (held)");
                        end
                        if (en) begin
                            lat = en_cnt - q_stamp[d][0];
                            checks++;
                            if (lat != ps_of(d)) begin
                                errors++;
                                $display("FAIL latency dut%0d vec%0d: got %0d required %0d", d, k, lat, ps_of(d));
                            end
                            void'(q_idx[d].pop_front());
                            void'(q_stamp[d].pop_front());
                        end
                    end
                end
            end
            if (in_valid && en) begin
                for (int d = 0; d < 3; d++) begin
                    q_idx[d].push_back(cur_idx);
                    q_stamp[d].push_back(en_cnt);
                end
            end
        end
    end

    initial begin
        int t;
        checks  = 0;
        errors  = 0;
        en_cnt  = 0;
        cur_idx = 0;
        //     k  m     s     r0      i0      r1      i1      y0r     y0i     y1r     y1i     ovf
        setv(0, 1'b0, 1'b0, 100,    50,     30,     -20,    130,    30,     70,     70,     1'b0);
        setv(1, 1'b1, 1'b0, 100,    50,     30,     -20,    120,    80,     80,     20,     1'b0);
        setv(2, 1'b0, 1'b0, 30000,  0,      10000,  0,      32767,  0,      20000,  0,      1'b1);
        setv(3, 1'b0, 1'b1, 32767,  0,      32767,  0,      32767,  0,      0,      0,      1'b0);
        setv(4, 1'b0, 1'b1, -3,     0,      0,      0,      -1,     0,      -1,     0,      1'b0);
        setv(5, 1'b1, 1'b0, -30000, -32768, -1,     10000,  -32768, -32768, -20000, -32767, 1'b1);
        setv(6, 1'b1, 1'b1, 5,      -7,     2,      3,      1,      -2,     4,      -4,     1'b0);
        setv(7, 1'b0, 1'b0, -32768, 32767,  -32768, -32768, -32768, -1,     0,      32767,  1'b1);
        setv(8, 1'b0, 1'b1, -32768, 1,      -32768, 0,      -32768, 1,      0,      1,      1'b0);

        rst_n = 1'b1; en = 1'b1; in_valid = 1'b0; ovf_clr = 1'b0;
        mode = 1'b0; scale = 1'b0; r0 = '0; i0 = '0; r1 = '0; i1 = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check_idle("reset_state");
        rst_n = 1'b1;

        // Isolated samples separated by bubbles.
        for (int k = 0; k < NV; k++) begin
            drive(k, 1'b1);
            repeat (5) drive(0, 1'b0);
            if (k == 2) begin
                #1;
                check_sticky("sticky_set", 1'b1);
                @(posedge clk); #1 ovf_clr = 1'b1;
                @(posedge clk); #1 ovf_clr = 1'b0;
                check_sticky("sticky_clear", 1'b0);
            end
        end

        // Back-to-back stream with a three-cycle stall in the middle.
        for (int k = 0; k < 8; k++) begin
            drive(k, 1'b1);
            if (k == 3) stall(3);
        end
        repeat (8) drive(0, 1'b0);

        // Reset with two samples in flight.
        drive(0, 1'b1);
        drive(1, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if (ov[0] !== 1'b1) begin
            errors++;
            $display("FAIL inflight_before_reset dut0: out_valid=%0b required 1", ov[0]);
        end
        #1 rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        for (int d = 0; d < 3; d++) begin
            q_idx[d].delete();
            q_stamp[d].delete();
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (8) drive(0, 1'b0);
        drive(1, 1'b1);
        repeat (8) drive(0, 1'b0);

        t = 0;
        while ((q_idx[0].size() + q_idx[1].size() + q_idx[2].size()) != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (q_idx[d].size() != 0) begin
                errors++;
                $display("FAIL drain dut%0d: %0d samples outstanding required 0", d, q_idx[d].size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
